// File: rtl/bsg_counter_dynamic_limit_ctrl_if.sv
// Bundle of the configuration handshake, run control and counter link signals
// for bsg_counter_dynamic_limit_ctrl. The slave modport is the controller's view;
// the master modport is the view of whatever drives it and hosts the counter.
interface bsg_counter_dynamic_limit_ctrl_if #(
   parameter int unsigned width_p      = 16,
   parameter int unsigned wrap_width_p = 8
);

   // Configuration handshake
   logic                    cfg_v_i;
   logic [width_p-1:0]      cfg_limit_i;
   logic                    cfg_oneshot_i;
   logic                    cfg_ready_o;

   // Run control
   logic                    start_i;
   logic                    stop_i;

   // Link to the dynamic-limit counter
   logic                    counter_en_o;
   logic [width_p-1:0]      counter_limit_o;
   logic                    counter_overflowed_i;

   // Status
   logic                    tick_o;
   logic [wrap_width_p-1:0] wrap_count_o;
   logic                    busy_o;
   logic                    done_o;

   modport master (
      output cfg_v_i,
      output cfg_limit_i,
      output cfg_oneshot_i,
      input  cfg_ready_o,
      output start_i,
      output stop_i,
      input  counter_en_o,
      input  counter_limit_o,
      output counter_overflowed_i,
      input  tick_o,
      input  wrap_count_o,
      input  busy_o,
      input  done_o
   );

   modport slave (
      input  cfg_v_i,
      input  cfg_limit_i,
      input  cfg_oneshot_i,
      output cfg_ready_o,
      input  start_i,
      input  stop_i,
      output counter_en_o,
      output counter_limit_o,
      input  counter_overflowed_i,
      output tick_o,
      output wrap_count_o,
      output busy_o,
      output done_o
   );

endinterface

// File: rtl/bsg_counter_dynamic_limit_ctrl.sv
// Control stage for a dynamic-limit enabled counter. Accepts new period limits
// over a valid/ready handshake, holds them in a one-deep shadow slot while the
// counter runs and only swaps them in at a period boundary, so no period is ever
// truncated or skipped. Also sequences run/pause/one-shot and reports wraps.
module bsg_counter_dynamic_limit_ctrl #(
   parameter int unsigned        width_p       = 16,
   parameter int unsigned        wrap_width_p  = 8,
   parameter logic [width_p-1:0] reset_limit_p = '0
) (
   input logic                             clk_i,
   input logic                             reset_i,
   bsg_counter_dynamic_limit_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e                  state_q, state_d;
   logic                    busy_q;
   logic                    done_q;

   logic [width_p-1:0]      active_limit_q;
   logic                    active_oneshot_q;
   logic [width_p-1:0]      staged_limit_q;
   logic                    staged_oneshot_q;
   logic                    pending_q;

   logic                    tick_q;
   logic [wrap_width_p-1:0] wrap_count_q;

   logic                    running;
   logic                    wrap;
   logic                    accept;
   logic                    wrap_count_max;
   logic                    release_staged;
   logic                    load_direct;
   logic                    load_staged;

   // Decode the cycle's events from the current registers and inputs.
   always_comb begin
      running        = (state_q == StRun);
      wrap           = running & bus.counter_overflowed_i;
      accept         = bus.cfg_v_i & ~pending_q;
      wrap_count_max = &wrap_count_q;
      // A staged config is released at a period boundary or when a stop ends
      // the run; accept cannot coincide since the slot is full.
      release_staged = running & pending_q & (wrap | bus.stop_i);
      // Outside RUN there is no period to protect; a wrap edge is itself a
      // boundary, so the new config can take effect immediately.
      load_direct    = accept & (~running | wrap);
      load_staged    = accept & running & ~wrap;
   end

   // Next-state decision; stop always beats start, and the one-shot decision
   // uses the oneshot flag of the period that is ending.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start_i & ~bus.stop_i) state_d = StRun;
         end
         StRun: begin
            if (bus.stop_i) begin
               state_d = StIdle;
            end else if (wrap & active_oneshot_q) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // All state: FSM, active/staged config, wrap tick and saturating wrap count.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q          <= StIdle;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         active_limit_q   <= reset_limit_p;
         active_oneshot_q <= 1'b0;
         staged_limit_q   <= '0;
         staged_oneshot_q <= 1'b0;
         pending_q        <= 1'b0;
         tick_q           <= 1'b0;
         wrap_count_q     <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == StRun);
         done_q  <= (state_d == StDone);

         tick_q  <= wrap;

         // A config accepted while stopped starts a fresh wrap history; no
         // wrap can occur in that cycle, so the two branches never collide.
         if (accept & ~running) begin
            wrap_count_q <= '0;
         end else if (wrap & ~wrap_count_max) begin
            wrap_count_q <= wrap_count_q + wrap_width_p'(1);
         end

         if (release_staged) begin
            active_limit_q   <= staged_limit_q;
            active_oneshot_q <= staged_oneshot_q;
            pending_q        <= 1'b0;
         end else if (load_direct) begin
            active_limit_q   <= bus.cfg_limit_i;
            active_oneshot_q <= bus.cfg_oneshot_i;
         end else if (load_staged) begin
            staged_limit_q   <= bus.cfg_limit_i;
            staged_oneshot_q <= bus.cfg_oneshot_i;
            pending_q        <= 1'b1;
         end
      end
   end

   // Outputs: counter enable decodes the state register directly so the counter
   // freezes on the same edge the FSM leaves RUN.
   always_comb begin
      bus.cfg_ready_o     = ~pending_q;
      bus.counter_en_o    = running;
      bus.counter_limit_o = active_limit_q;
      bus.tick_o          = tick_q;
      bus.wrap_count_o    = wrap_count_q;
      bus.busy_o          = busy_q;
      bus.done_o          = done_q;
   end

endmodule

// File: tb/tb_bsg_counter_dynamic_limit_ctrl.sv
// Bench for bsg_counter_dynamic_limit_ctrl: two instances (8-bit and 2-bit wrap
// counters) share one stimulus stream, each driving its own counter emulation.
// A reference model tracks period position, config and wraps arithmetically.
module tb_bsg_counter_dynamic_limit_ctrl;

   localparam int unsigned  W      = 8;
   localparam int unsigned  WA     = 8;
   localparam int unsigned  WB     = 2;
   localparam logic [W-1:0] RstLim = 8'd7;
   localparam int           Mod    = 1 << W;
   localparam int           MaxA   = (1 << WA) - 1;
   localparam int           MaxB   = (1 << WB) - 1;
   localparam int           MIdle  = 0;
   localparam int           MRun   = 1;
   localparam int           MDone  = 2;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst     = 1'b1;
   logic         cfg_v   = 1'b0;
   logic [W-1:0] cfg_lim = '0;
   logic         cfg_os  = 1'b0;
   logic         start   = 1'b0;
   logic         stop    = 1'b0;

   bsg_counter_dynamic_limit_ctrl_if #(.width_p(W), .wrap_width_p(WA)) if_a ();
   bsg_counter_dynamic_limit_ctrl_if #(.width_p(W), .wrap_width_p(WB)) if_b ();

   assign if_a.cfg_v_i       = cfg_v;
   assign if_a.cfg_limit_i   = cfg_lim;
   assign if_a.cfg_oneshot_i = cfg_os;
   assign if_a.start_i       = start;
   assign if_a.stop_i        = stop;
   assign if_b.cfg_v_i       = cfg_v;
   assign if_b.cfg_limit_i   = cfg_lim;
   assign if_b.cfg_oneshot_i = cfg_os;
   assign if_b.start_i       = start;
   assign if_b.stop_i        = stop;

   bsg_counter_dynamic_limit_ctrl #(
      .width_p(W), .wrap_width_p(WA), .reset_limit_p(RstLim)
   ) dut_a (
      .clk_i(clk), .reset_i(rst), .bus(if_a.slave)
   );

   bsg_counter_dynamic_limit_ctrl #(
      .width_p(W), .wrap_width_p(WB), .reset_limit_p(RstLim)
   ) dut_b (
      .clk_i(clk), .reset_i(rst), .bus(if_b.slave)
   );

   // Counter emulation for each DUT (the downstream dynamic-limit counter).
   logic [W-1:0] env_a, env_b;
   assign if_a.counter_overflowed_i = (W'(env_a + W'(1)) == if_a.counter_limit_o);
   assign if_b.counter_overflowed_i = (W'(env_b + W'(1)) == if_b.counter_limit_o);

   always @(posedge clk) begin
      if (rst) begin
         env_a <= '0;
         env_b <= '0;
      end else begin
         if (if_a.counter_en_o) env_a <= if_a.counter_overflowed_i ? '0 : W'(env_a + W'(1));
         if (if_b.counter_en_o) env_b <= if_b.counter_overflowed_i ? '0 : W'(env_b + W'(1));
      end
   end

   // Reference model state.
   int m_state, m_lim, m_os, m_pend, m_stg_lim, m_stg_os, m_tick, m_wraps, m_cnt;

   always @(posedge clk) begin : ref_model
      bit run, wrap, acc;
      if (rst) begin
         m_state <= MIdle; m_lim <= int'(RstLim); m_os <= 0; m_pend <= 0;
         m_stg_lim <= 0; m_stg_os <= 0; m_tick <= 0; m_wraps <= 0; m_cnt <= 0;
      end else begin
         run  = (m_state == MRun);
         wrap = run && (((m_cnt + 1) % Mod) == m_lim);
         acc  = cfg_v && (m_pend == 0);
         m_tick <= int'(wrap);
         if (run) m_cnt <= wrap ? 0 : m_cnt + 1;
         if (acc && !run) m_wraps <= 0;
         else if (wrap) m_wraps <= m_wraps + 1;
         // Config bookkeeping: boundary or stop releases the staged value.
         if (run && (m_pend != 0) && (wrap || stop)) begin
            m_lim <= m_stg_lim; m_os <= m_stg_os; m_pend <= 0;
         end else if (acc && (!run || wrap)) begin
            m_lim <= int'(cfg_lim); m_os <= int'(cfg_os);
         end else if (acc) begin
            m_stg_lim <= int'(cfg_lim); m_stg_os <= int'(cfg_os); m_pend <= 1;
         end
         // Sequencing.
         if (run) begin
            if (stop) m_state <= MIdle;
            else if (wrap && (m_os != 0)) m_state <= MDone;
         end else if (start && !stop) begin
            m_state <= MRun;
         end
      end
   end

   int n_pass   = 0;
   int n_checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_all();
      int wa, wb;
      wa = (m_wraps > MaxA) ? MaxA : m_wraps;
      wb = (m_wraps > MaxB) ? MaxB : m_wraps;
      chk("a_en",    32'(if_a.counter_en_o),    32'(m_state == MRun));
      chk("a_limit", 32'(if_a.counter_limit_o), 32'(m_lim));
      chk("a_ready", 32'(if_a.cfg_ready_o),     32'(m_pend == 0));
      chk("a_tick",  32'(if_a.tick_o),          32'(m_tick));
      chk("a_wraps", 32'(if_a.wrap_count_o),    32'(wa));
      chk("a_busy",  32'(if_a.busy_o),          32'(m_state == MRun));
      chk("a_done",  32'(if_a.done_o),          32'(m_state == MDone));
      chk("b_en",    32'(if_b.counter_en_o),    32'(m_state == MRun));
      chk("b_limit", 32'(if_b.counter_limit_o), 32'(m_lim));
      chk("b_ready", 32'(if_b.cfg_ready_o),     32'(m_pend == 0));
      chk("b_tick",  32'(if_b.tick_o),          32'(m_tick));
      chk("b_wraps", 32'(if_b.wrap_count_o),    32'(wb));
      chk("b_busy",  32'(if_b.busy_o),          32'(m_state == MRun));
      chk("b_done",  32'(if_b.done_o),          32'(m_state == MDone));
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check_all();
      end
   endtask

   task automatic cfg(input logic [W-1:0] lim, input logic os);
      cfg_v = 1'b1; cfg_lim = lim; cfg_os = os;
      step(1);
      cfg_v = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   initial begin : stim
      int ticks;

      // Reset state
      step(2);
      rst = 1'b0;
      chk("rst_ready", 32'(if_a.cfg_ready_o), 32'd1);
      chk("rst_limit", 32'(if_a.counter_limit_o), 32'd7);
      chk("rst_en", 32'(if_a.counter_en_o), 32'd0);
      chk("rst_wraps", 32'(if_a.wrap_count_o), 32'd0);
      chk("rst_busy", 32'(if_a.busy_o), 32'd0);

      // Free run at limit 4
      cfg(8'd4, 1'b0);
      pulse_start();
      chk("run_en", 32'(if_a.counter_en_o), 32'd1);
      chk("run_busy", 32'(if_a.busy_o), 32'd1);
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         ticks += int'(if_a.tick_o);
      end
      chk("lim4_ticks", 32'(ticks), 32'd3);
      chk("lim4_wraps", 32'(if_a.wrap_count_o), 32'd3);

      // Limit change mid-period is held until the wrap
      step(2);
      cfg(8'd2, 1'b0);
      chk("stage_ready", 32'(if_a.cfg_ready_o), 32'd0);
      chk("stage_limit", 32'(if_a.counter_limit_o), 32'd4);
      step(1);
      chk("swap_limit", 32'(if_a.counter_limit_o), 32'd2);
      chk("swap_ready", 32'(if_a.cfg_ready_o), 32'd1);
      ticks = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         ticks += int'(if_a.tick_o);
      end
      chk("lim2_ticks", 32'(ticks), 32'd4);

      // One-shot at limit 3
      stop = 1'b1; step(1); stop = 1'b0;
      cfg(8'd3, 1'b1);
      pulse_start();
      ticks = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         ticks += int'(if_a.tick_o);
      end
      chk("os_ticks", 32'(ticks), 32'd1);
      chk("os_done", 32'(if_a.done_o), 32'd1);
      chk("os_en", 32'(if_a.counter_en_o), 32'd0);
      pulse_start();
      step(1); chk("os2_tick1", 32'(if_a.tick_o), 32'd0);
      step(1); chk("os2_tick2", 32'(if_a.tick_o), 32'd0);
      step(1); chk("os2_tick3", 32'(if_a.tick_o), 32'd1);
      chk("os2_done", 32'(if_a.done_o), 32'd1);

      // Pause and resume mid-period at limit 5
      cfg(8'd5, 1'b0);
      pulse_start();
      step(1);
      stop = 1'b1; step(1); stop = 1'b0;
      step(10);
      start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
      chk("stop_wins", 32'(if_a.busy_o), 32'd0);
      pulse_start();
      step(1); chk("resume_t1", 32'(if_a.tick_o), 32'd0);
      step(1); chk("resume_t2", 32'(if_a.tick_o), 32'd0);
      step(1); chk("resume_t3", 32'(if_a.tick_o), 32'd1);

      // Limit 1: staged, then a wrap every enabled cycle
      cfg(8'd1, 1'b0);
      chk("l1_pending", 32'(if_a.cfg_ready_o), 32'd0);
      step(4);
      chk("l1_limit", 32'(if_a.counter_limit_o), 32'd1);
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk("l1_tick", 32'(if_a.tick_o), 32'd1);
      end
      chk("sat_b", 32'(if_b.wrap_count_o), 32'd3);

      // Reset mid-run with a pending config
      cfg(8'd6, 1'b0);
      chk("wrap_direct", 32'(if_a.counter_limit_o), 32'd6);
      step(2);
      cfg(8'd2, 1'b0);
      chk("pend_ready", 32'(if_a.cfg_ready_o), 32'd0);
      rst = 1'b1; step(1); rst = 1'b0;
      chk("mid_rst_limit", 32'(if_a.counter_limit_o), 32'd7);
      chk("mid_rst_ready", 32'(if_a.cfg_ready_o), 32'd1);
      chk("mid_rst_wraps", 32'(if_a.wrap_count_o), 32'd0);
      chk("mid_rst_tick", 32'(if_a.tick_o), 32'd0);
      chk("mid_rst_en", 32'(if_a.counter_en_o), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 399) == 0);
         start   = ($urandom_range(0, 9) == 0);
         stop    = ($urandom_range(0, 19) == 0);
         cfg_v   = !stop && ($urandom_range(0, 4) == 0);
         cfg_lim = W'($urandom_range(0, 12));
         cfg_os  = 1'($urandom_range(0, 1));
         step(1);
      end
      rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_v = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bsg_counter_dynamic_limit_ctrl.md
Name: bsg_counter_dynamic_limit_ctrl

Overview:
- Control stage directly upstream of the dynamic-limit enabled counter. It drives the counter's en_i and limit_i, and consumes its overflowed_o.
- Accepts new limits over a valid/ready handshake and stages them in a one-deep shadow register. A staged limit is applied only at a period boundary (wrap), so a period is never truncated or missed.
- Provides run/pause/one-shot sequencing, a registered wrap tick, and a saturating wrap count for timer and rate-generator users.

Parameters:
- width_p, 16, width of limit and counter interface.
- wrap_width_p, 8, width of wrap_count_o.
- reset_limit_p, 0, active limit after reset; must fit in width_p. Value 0 means a period of 2^width_p.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- cfg_v_i  in  1  new configuration valid.
- cfg_limit_i  in  width_p  requested period limit.
- cfg_oneshot_i  in  1  1 = stop after one period; 0 = free-run.
- cfg_ready_o  out  1  staging slot free; a transfer occurs when cfg_v_i & cfg_ready_o.
- start_i  in  1  begin or resume counting.
- stop_i  in  1  pause counting.
- counter_en_o  out  1  to counter en_i.
- counter_limit_o  out  width_p  to counter limit_i; equals the active limit register.
- counter_overflowed_i  in  1  from counter overflowed_o (combinational: counter+1 == limit).
- tick_o  out  1  one-cycle pulse, registered, one cycle after each wrap.
- wrap_count_o  out  wrap_width_p  saturating count of wraps.
- busy_o  out  1  state == RUN.
- done_o  out  1  state == DONE.

Behaviour:
- Reset: all of the following take effect at the clock edge on which reset_i is sampled high, regardless of state or of any pending config.
  - state = IDLE; active_limit = reset_limit_p; active_oneshot = 0; pending = 0.
  - Outputs: tick_o = 0, wrap_count_o = 0, counter_en_o = 0, cfg_ready_o = 1, busy_o = 0, done_o = 0.
- wrap = counter_en_o & counter_overflowed_i. A wrap occurs on the edge where the counter returns to 0.
- counter_en_o = (state == RUN), combinational from the state register.
- States:
  - IDLE (paused): counter frozen.
  - RUN: counting.
  - DONE: one-shot complete; counter sits at 0.
- Transitions:
  - IDLE --start_i & ~stop_i--> RUN.
  - RUN --stop_i--> IDLE.
  - RUN --wrap & active_oneshot & ~stop_i--> DONE.
  - DONE --start_i & ~stop_i--> RUN.
  - Ignored: start_i in RUN, stop_i in IDLE or DONE.
  - start_i and stop_i in the same cycle: stop wins. RUN goes to IDLE; in IDLE or DONE the state is unchanged.
- Pause semantics: this block cannot clear the counter. Stop then start resumes mid-period, and the counter value is retained.
- cfg_ready_o = ~pending.
- Accepted cfg while state != RUN: written directly to active_limit/active_oneshot at that edge; pending stays 0; wrap_count_o clears to 0.
- Accepted cfg while RUN:
  - If no wrap in the same cycle: stored in staging; pending = 1.
  - If a wrap occurs in the same cycle: written directly to active at that edge.
- On wrap with pending = 1: staging moves to active at that edge; pending = 0. The new limit governs the next period starting from counter = 0.
- The RUN to DONE decision uses the oneshot value active before any same-edge update.
- If state leaves RUN via stop_i while pending = 1: the staged config moves to active at that edge; pending = 0.
- tick_o asserts in the cycle after each wrap, for exactly 1 cycle.
- wrap_count_o increments on each wrap and saturates at 2^wrap_width_p - 1.
- Period arithmetic: limit L >= 1 gives L enabled cycles per period. L = 1 gives a wrap every enabled cycle. L = 0 gives 2^width_p cycles.
- reset_i has priority over every other input at that edge.

Test Plan:
- Reset, then cfg limit=4 oneshot=0, then start -> counter_en_o = 1; tick_o pulses every 4 cycles; wrap_count_o = 1, 2, 3…; busy_o = 1.
- While RUN at limit=4, cfg limit=2 two cycles into a period -> cfg_ready_o drops and counter_limit_o stays 4 until the wrap. Subsequent ticks come every 2 cycles; cfg_ready_o returns to 1 after the wrap.
- cfg limit=3 oneshot=1, start -> exactly one tick_o 3 cycles later; state DONE; done_o = 1; counter_en_o = 0; a second start produces one more tick after 3 cycles.
- RUN at limit=5, stop after 2 cycles, idle 10 cycles, start -> first tick arrives 3 enabled cycles after resume. Also assert start and stop together: stop wins.
- limit=1 free-run with wrap_width_p=2 -> tick_o held high continuously after its first cycle; wrap_count_o saturates at 3.
- Assert reset_i mid-RUN with a pending cfg -> next cycle: IDLE, counter_limit_o = reset_limit_p, cfg_ready_o = 1, wrap_count_o = 0, tick_o = 0.
